hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the multicycle datapath.
- Owns the HI and LO result registers; the main control FSM drives the write-data mux from them (mfhi/mflo).
- Generalises the fixed 32-bit HI/LO pair to WIDTH bits and adds:
  - signed/unsigned multiply and divide,
  - a start/busy/done handshake,
  - divide-by-zero flagging.

Parameters:
- WIDTH, 32: operand width; hi and lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH): iteration counter width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request operation; sampled only when busy=0.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
- a  input  WIDTH  operand A (multiplicand/dividend); sampled with start.
- b  input  WIDTH  operand B (multiplier/divisor); sampled with start.
- busy  output  1  operation in progress; start ignored while 1.
- done  output  1  single-cycle pulse: result (or div_zero) valid.
- div_zero  output  1  valid with done; 1 = DIV/DIVU with b==0.
- hi  output  WIDTH  HI register: product upper half, or remainder.
- lo  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter and working registers cleared. Reset mid-operation aborts it: no done, and hi/lo go to 0.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - If start=1 and the op is DIV/DIVU with b==0: stay in IDLE. Next cycle shows done=1 and div_zero=1. hi/lo are unchanged and busy stays 0.
  - Else if start=1: latch operand magnitudes (absolute value for signed ops, raw for unsigned) and the result-sign flags, clear counter, go to RUN.
- Sign flags:
  - MULT: neg_p = a[W-1]^b[W-1].
  - DIV: neg_q = a[W-1]^b[W-1]; neg_r = a[W-1].
- RUN: exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add on 2W-bit accumulator.
  - Divide: restoring shift-subtract; W-bit remainder is held with one extra bit for the subtract.
  - Counter == WIDTH-1 -> go to FINISH.
- FINISH (1 cycle): apply sign fix-up, write hi/lo, set done=1 for the following cycle, go to IDLE.
  - Multiply: {hi,lo} = neg_p ? -P : P.
  - Divide: lo = neg_q ? -Q : Q; hi = neg_r ? -R : R.
- Timing, with start accepted in cycle 0:
  - busy=1 in cycles 1..WIDTH+1.
  - done=1, busy=0 and new hi/lo visible in cycle WIDTH+2 (cycle 34 at WIDTH=32).
  - A new start is accepted in that same done cycle.
- done is a single-cycle pulse; div_zero is 0 whenever done=0.
- start while busy=1 is ignored; op/a/b changes during RUN have no effect.
- Overflow case (signed DIV of most-negative by -1): lo = most-negative (magnitude wraps), hi = 0. No flag.
- hi/lo hold their value between completed operations; a divide-by-zero never modifies them.
- Multiply of most-negative by most-negative is exact: the magnitude 2^(W-1) fits in the W-bit unsigned working operand.

Decomposition:
- Shared package cpu_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU),
  - FSM state typedef (IDLE/RUN/FINISH).
- One natural sub-module: muldiv_signfix.
  - Combinational magnitude/negation helper.
  - Used at operand latch and at the FINISH fix-up.
- FSM, counter and datapath stay in hilo_muldiv_unit.

Test Plan (WIDTH=32):
- MULT a=FFFFFFFD (-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB; done exactly in cycle 34; busy high cycles 1..33.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; then MULT 80000000*80000000 -> hi=40000000, lo=00000000.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=00000064, b=00000007 -> lo=0000000E, hi=00000002.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
- DIVU with b=0 after a prior result hi=2, lo=E -> done=1 and div_zero=1 in cycle 1, busy never rises, hi/lo stay 2/E.
- Start pulse during RUN (cycle 10, different operands) ignored, first result intact. Reset driven low at cycle 15 of a MULT -> busy=0, hi=lo=0 immediately, no done pulse. A new op after release completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle datapath: mul/div opcodes and the
// HI/LO unit control states.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op_v);
        return op_v[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_v);
        return ~op_v[0];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: magnitude of a signed operand on the
// way in, sign restoration of the unsigned result on the way out.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? ({W{1'b0}} - val_i) : val_i;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative WIDTH-bit multiply/divide unit owning the HI/LO result registers;
// one result bit per cycle with a start/busy/done handshake.
module hilo_muldiv_unit
    import cpu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   is_div_q, is_div_d;
    logic                   sgn_xor_q, sgn_xor_d;
    logic                   sgn_a_q, sgn_a_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   dz_q, dz_d;

    logic                   signed_op_s;
    logic [WIDTH-1:0]       mag_a_s, mag_b_s;
    logic [2*WIDTH-1:0]     prod_fix_s;
    logic [WIDTH-1:0]       quo_fix_s, rem_fix_s;
    logic [WIDTH:0]         mul_sum_s;
    logic [2*WIDTH-1:0]     mul_next_s;
    logic [WIDTH:0]         div_shift_s, div_diff_s;
    logic                   div_ge_s;

    assign signed_op_s = op_is_signed(op);

    muldiv_signfix #(.W(WIDTH)) u_abs_a (
        .val_i (a),
        .neg_i (signed_op_s & a[WIDTH-1]),
        .res_o (mag_a_s)
    );

    muldiv_signfix #(.W(WIDTH)) u_abs_b (
        .val_i (b),
        .neg_i (signed_op_s & b[WIDTH-1]),
        .res_o (mag_b_s)
    );

    muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
        .val_i (acc_q),
        .neg_i (sgn_xor_q),
        .res_o (prod_fix_s)
    );

    muldiv_signfix #(.W(WIDTH)) u_fix_quo (
        .val_i (acc_q[WIDTH-1:0]),
        .neg_i (sgn_xor_q),
        .res_o (quo_fix_s)
    );

    muldiv_signfix #(.W(WIDTH)) u_fix_rem (
        .val_i (rem_q),
        .neg_i (sgn_a_q),
        .res_o (rem_fix_s)
    );

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next_s = acc_q[0] ? {mul_sum_s, acc_q[WIDTH-1:1]}
                                 : {1'b0, acc_q[2*WIDTH-1:1]};

    // Since rem < divisor, the trial difference always fits in WIDTH+1 bits
    // two's complement, so its MSB is the borrow.
    assign div_shift_s = {rem_q, acc_q[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_q};
    assign div_ge_s    = ~div_diff_s[WIDTH];

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        sgn_xor_d = sgn_xor_q;
        sgn_a_d   = sgn_a_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_is_div(op) && (b == {WIDTH{1'b0}})) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        is_div_d  = op_is_div(op);
                        sgn_xor_d = signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sgn_a_d   = signed_op_s & a[WIDTH-1];
                        acc_d     = {{WIDTH{1'b0}}, (op_is_div(op) ? mag_a_s : mag_b_s)};
                        opnd_d    = op_is_div(op) ? mag_b_s : mag_a_s;
                        rem_d     = {WIDTH{1'b0}};
                        cnt_d     = {CNT_W{1'b0}};
                        state_d   = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    rem_d = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge_s};
                end else begin
                    acc_d = mul_next_s;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = FINISH;
                end else begin
                    state_d = RUN;
                end
            end
            FINISH: begin
                if (is_div_q) begin
                    hi_d = rem_fix_s;
                    lo_d = quo_fix_s;
                end else begin
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, working and result registers; reset aborts any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            is_div_q  <= 1'b0;
            sgn_xor_q <= 1'b0;
            sgn_a_q   <= 1'b0;
            acc_q     <= {(2*WIDTH){1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            opnd_q    <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            sgn_xor_q <= sgn_xor_d;
            sgn_a_q   <= sgn_a_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit at WIDTH=32.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int tests = 0;
    int fails = 0;

    int   obs_done_cyc, obs_busy_n, obs_busy_first, obs_busy_last, obs_stray;
    logic obs_dz;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Issue one op in the current cycle (cycle 0) and record the handshake
    // until done or a 45-cycle budget runs out. Operands are scrambled from
    // cycle 1 on; an optional extra start (div-by-zero) is pulsed at poke_cyc.
    task automatic run_op(input logic [1:0] op_v, input logic [W-1:0] a_v,
                          input logic [W-1:0] b_v, input int poke_cyc);
        op = op_v; a = a_v; b = b_v; start = 1'b1;
        obs_done_cyc = -1; obs_busy_n = 0; obs_busy_first = -1;
        obs_busy_last = -1; obs_stray = 0; obs_dz = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 1) begin
                op = ~op_v; a = ~a_v; b = ~b_v;
            end
            if (k == poke_cyc) begin
                start = 1'b1; op = 2'b11; a = 32'h0000_0005; b = 32'h0000_0000;
            end
            if (busy === 1'b1) begin
                obs_busy_n++;
                if (obs_busy_first < 0) obs_busy_first = k;
                obs_busy_last = k;
            end
            if (done === 1'b1) begin
                obs_done_cyc = k;
                obs_dz = div_zero;
                break;
            end else if (div_zero !== 1'b0) begin
                obs_stray++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got=%h exp=0", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got=%h exp=0", lo); end
    endtask

    task automatic test_mult();
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        tests++; if (obs_done_cyc != 34) begin fails++; $display("FAIL mult_done_cycle got=%0d exp=34", obs_done_cyc); end
        tests++; if (obs_busy_first != 1 || obs_busy_last != 33 || obs_busy_n != 33) begin
            fails++; $display("FAIL mult_busy_window got=%0d..%0d n=%0d exp=1..33 n=33", obs_busy_first, obs_busy_last, obs_busy_n); end
        tests++; if (obs_dz !== 1'b0 || obs_stray != 0) begin fails++; $display("FAIL mult_dz got=%b stray=%0d exp=0", obs_dz, obs_stray); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        tests++; if (lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
    endtask

    task automatic test_back_to_back();
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        tests++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        tests++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        tests++; if (obs_done_cyc != 34) begin fails++; $display("FAIL b2b_done_cycle got=%0d exp=34", obs_done_cyc); end
        tests++; if (hi !== 32'h4000_0000) begin fails++; $display("FAIL mult_minneg_hi got=%h exp=40000000", hi); end
        tests++; if (lo !== 32'h0000_0000) begin fails++; $display("FAIL mult_minneg_lo got=%h exp=00000000", lo); end
    endtask

    task automatic test_div();
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        tests++; if (obs_done_cyc != 34) begin fails++; $display("FAIL divovf_done_cycle got=%0d exp=34", obs_done_cyc); end
        tests++; if (obs_dz !== 1'b0) begin fails++; $display("FAIL divovf_dz got=%b exp=0", obs_dz); end
        tests++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
        tests++; if (hi !== 32'h0000_0000) begin fails++; $display("FAIL divovf_hi got=%h exp=00000000", hi); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        run_op(2'b11, 32'h0000_0064, 32'h0000_0007, 0);
        tests++; if (obs_busy_n != 33) begin fails++; $display("FAIL divu_busy_n got=%0d exp=33", obs_busy_n); end
        tests++; if (lo !== 32'h0000_000E) begin fails++; $display("FAIL divu_lo got=%h exp=0000000e", lo); end
        tests++; if (hi !== 32'h0000_0002) begin fails++; $display("FAIL divu_hi got=%h exp=00000002", hi); end
    endtask

    task automatic test_div_zero();
        run_op(2'b11, 32'h0000_1234, 32'h0000_0000, 0);
        tests++; if (obs_done_cyc != 1) begin fails++; $display("FAIL dz_done_cycle got=%0d exp=1", obs_done_cyc); end
        tests++; if (obs_dz !== 1'b1) begin fails++; $display("FAIL dz_flag got=%b exp=1", obs_dz); end
        tests++; if (obs_busy_n != 0) begin fails++; $display("FAIL dz_busy_n got=%0d exp=0", obs_busy_n); end
        tests++; if (hi !== 32'h0000_0002) begin fails++; $display("FAIL dz_hi_kept got=%h exp=00000002", hi); end
        tests++; if (lo !== 32'h0000_000E) begin fails++; $display("FAIL dz_lo_kept got=%h exp=0000000e", lo); end
        @(posedge clk); #1;
        tests++; if (done !== 1'b0 || div_zero !== 1'b0) begin
            fails++; $display("FAIL dz_pulse got=done %b dz %b exp=0 0", done, div_zero); end
    endtask

    task automatic test_ignored_start();
        run_op(2'b01, 32'h89AB_CDEF, 32'h0000_0010, 10);
        tests++; if (obs_done_cyc != 34) begin fails++; $display("FAIL poke_done_cycle got=%0d exp=34", obs_done_cyc); end
        tests++; if (obs_dz !== 1'b0 || obs_stray != 0) begin fails++; $display("FAIL poke_dz got=%b stray=%0d exp=0", obs_dz, obs_stray); end
        tests++; if (hi !== 32'h0000_0008) begin fails++; $display("FAIL poke_hi got=%h exp=00000008", hi); end
        tests++; if (lo !== 32'h9ABC_DEF0) begin fails++; $display("FAIL poke_lo got=%h exp=9abcdef0", lo); end
    endtask

    task automatic test_reset_mid_op();
        int done_seen;
        op = 2'b00; a = 32'h0000_0007; b = 32'h0000_0009; start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", hi, lo); end
        @(posedge clk); #1 reset = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        tests++; if (done_seen != 0) begin fails++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_seen); end
        run_op(2'b01, 32'h0000_0006, 32'h0000_0007, 0);
        tests++; if (obs_done_cyc != 34) begin fails++; $display("FAIL after_rst_done_cycle got=%0d exp=34", obs_done_cyc); end
        tests++; if (hi !== 32'h0 || lo !== 32'h0000_002A) begin fails++; $display("FAIL after_rst_result got=%h_%h exp=00000000_0000002a", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_div_zero();
        test_ignored_start();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
